// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - mode encoding shared by the T flip-flop bank and its cells
package tff_pkg;

    typedef enum logic [1:0] {
        TFF_MODE_TOGGLE = 2'b00,
        TFF_MODE_UP     = 2'b01,
        TFF_MODE_DOWN   = 2'b10,
        TFF_MODE_HOLD   = 2'b11
    } tff_mode_t;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flop with parallel load and async active-low reset
module tff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic toggle,
    input  logic load,
    input  logic load_bit,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RST_BIT;
        end else if (load) begin
            r_q <= load_bit;
        end else if (toggle) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tff_counter_bank.sv
// rtl/tff_counter_bank.sv - T flop bank: per-bit toggle or up/down counter
// Build option TFF_BANK_SAT_EN: counters saturate at the terminal value, no wrap pulse.
module tff_counter_bank
    import tff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    tff_mode_t        w_mode;
    logic [WIDTH-1:0] w_and_pre;
    logic [WIDTH-1:0] w_nor_pre;
    logic [WIDTH-1:0] w_toggle;
    logic             w_adv;
    logic             w_block;

    assign w_mode = tff_mode_t'(mode);

    // w_and_pre[i] = &q[i-1:0], w_nor_pre[i] = ~|q[i-1:0]; both are 1 for bit 0
    assign w_and_pre[0] = 1'b1;
    assign w_nor_pre[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_prefix
            assign w_and_pre[gi] = w_and_pre[gi-1] &  q[gi-1];
            assign w_nor_pre[gi] = w_nor_pre[gi-1] & ~q[gi-1];
        end
    endgenerate

    always_comb begin
        tc = 1'b0;
        case (w_mode)
            TFF_MODE_UP:   tc = &q;
            TFF_MODE_DOWN: tc = ~|q;
            default:       tc = 1'b0;
        endcase
    end

    assign w_adv = en && (w_mode != TFF_MODE_HOLD);

`ifdef TFF_BANK_SAT_EN
    assign w_block = tc;
`else
    assign w_block = 1'b0;
`endif

    always_comb begin
        w_toggle = '0;
        if (w_adv && !w_block) begin
            case (w_mode)
                TFF_MODE_TOGGLE: w_toggle = t;
                TFF_MODE_UP:     w_toggle = w_and_pre;
                TFF_MODE_DOWN:   w_toggle = w_nor_pre;
                default:         w_toggle = '0;
            endcase
        end
    end

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            tff_cell #(
                .RST_BIT (RESET_VAL[gi])
            ) u_cell (
                .clk      (clk),
                .reset    (reset),
                .toggle   (w_toggle[gi]),
                .load     (load),
                .load_bit (load_val[gi]),
                .q        (q[gi])
            );
        end
    endgenerate

`ifdef TFF_BANK_SAT_EN
    assign wrap = 1'b0;
`else
    logic r_wrap;

    // tc is only set in UP/DOWN, so an advancing edge at tc is exactly a wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= !load && en && tc;
        end
    end

    assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_tff_counter_bank.sv
// tb/tb_tff_counter_bank.sv - directed and model-checked bench for tff_counter_bank (WIDTH=4)
module tb_tff_counter_bank;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;

    int n_vec;
    int n_miscompare;

    logic [W-1:0] m_q;
    logic         m_wrap;
    logic         m_tc;

    tff_counter_bank #(
        .WIDTH     (W),
        .RESET_VAL (4'h0)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .t        (t),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic i_load, input logic [W-1:0] i_lv, input logic [1:0] i_mode,
                         input logic i_en, input logic [W-1:0] i_t);
        load = i_load; load_val = i_lv; mode = i_mode; en = i_en; t = i_t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step();
        logic [W-1:0] nq;
        logic         nw;
        nq = m_q;
        nw = 1'b0;
        if (load) begin
            nq = load_val;
        end else if (en && mode != 2'b11) begin
            case (mode)
                2'b00: nq = m_q ^ t;
                2'b01: begin
                    if (m_q == 4'hF) begin
`ifdef TFF_BANK_SAT_EN
                        nq = m_q;
`else
                        nq = 4'h0; nw = 1'b1;
`endif
                    end else nq = m_q + 4'h1;
                end
                default: begin
                    if (m_q == 4'h0) begin
`ifdef TFF_BANK_SAT_EN
                        nq = m_q;
`else
                        nq = 4'hF; nw = 1'b1;
`endif
                    end else nq = m_q - 4'h1;
                end
            endcase
        end
        m_q = nq;
        m_wrap = nw;
    endtask

    initial begin
        n_vec = 0;
        n_miscompare = 0;
        reset = 1'b0;
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'h0);
        #12;
        check("reset_q", q, 4'h0);
        check("reset_wrap", wrap, 1'b0);
        check("reset_tc", tc, 1'b0);
        reset = 1'b1;
        tick();

        // 1. asynchronous reset mid-count
        drive(1'b1, 4'h9, 2'b01, 1'b0, 4'h0);
        tick();
        check("t1_load9", q, 4'h9);
        drive(1'b0, 4'h0, 2'b01, 1'b1, 4'h0);
        #2;
        reset = 1'b0;
        #1;
        check("t1_async_q", q, 4'h0);
        check("t1_async_wrap", wrap, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("t1_up1", q, 4'h1);
        tick();
        check("t1_up2", q, 4'h2);
        tick();
        check("t1_up3", q, 4'h3);

        // 2. toggle mode
        drive(1'b1, 4'h0, 2'b00, 1'b0, 4'h0);
        tick();
        drive(1'b0, 4'h0, 2'b00, 1'b1, 4'b0101);
        tick();
        check("t2_tog1", q, 4'h5);
        check("t2_tc_toggle", tc, 1'b0);
        tick();
        check("t2_tog2", q, 4'h0);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 4'b1111);
        tick();
        check("t2_en0_hold", q, 4'h0);

`ifndef TFF_BANK_SAT_EN
        // 3. up wrap
        drive(1'b1, 4'hE, 2'b01, 1'b0, 4'h0);
        tick();
        drive(1'b0, 4'h0, 2'b01, 1'b1, 4'hF);
        tick();
        check("t3_q_f", q, 4'hF);
        check("t3_tc", tc, 1'b1);
        check("t3_wrap_pre", wrap, 1'b0);
        tick();
        check("t3_q_0", q, 4'h0);
        check("t3_wrap", wrap, 1'b1);
        tick();
        check("t3_q_1", q, 4'h1);
        check("t3_wrap_clr", wrap, 1'b0);

        // 4. down wrap
        drive(1'b1, 4'h1, 2'b10, 1'b0, 4'h0);
        tick();
        drive(1'b0, 4'h0, 2'b10, 1'b1, 4'h0);
        tick();
        check("t4_q_0", q, 4'h0);
        check("t4_tc", tc, 1'b1);
        tick();
        check("t4_q_f", q, 4'hF);
        check("t4_wrap", wrap, 1'b1);
        check("t4_tc_f", tc, 1'b0);
        tick();
        check("t4_q_e", q, 4'hE);
        check("t4_wrap_clr", wrap, 1'b0);
`else
        // 6. saturating build
        drive(1'b1, 4'hE, 2'b01, 1'b0, 4'h0);
        tick();
        check("t6_up_e", q, 4'hE);
        drive(1'b0, 4'h0, 2'b01, 1'b1, 4'h0);
        tick();
        check("t6_up_f", q, 4'hF);
        check("t6_tc", tc, 1'b1);
        tick();
        check("t6_up_f2", q, 4'hF);
        check("t6_wrap2", wrap, 1'b0);
        tick();
        check("t6_up_f3", q, 4'hF);
        check("t6_wrap3", wrap, 1'b0);
        drive(1'b1, 4'h1, 2'b10, 1'b0, 4'h0);
        tick();
        check("t6_dn_1", q, 4'h1);
        drive(1'b0, 4'h0, 2'b10, 1'b1, 4'h0);
        tick();
        check("t6_dn_0", q, 4'h0);
        tick();
        check("t6_dn_0b", q, 4'h0);
        check("t6_dn_wrap", wrap, 1'b0);
`endif

        // 5. load beats an advancing UP at all ones
        drive(1'b1, 4'hF, 2'b01, 1'b0, 4'h0);
        tick();
        check("t5_tc_f", tc, 1'b1);
        drive(1'b1, 4'hA, 2'b01, 1'b1, 4'h0);
        tick();
        check("t5_load_a", q, 4'hA);
        check("t5_wrap", wrap, 1'b0);
        drive(1'b0, 4'h3, 2'b11, 1'b1, 4'hF);
        tick();
        check("t5_hold", q, 4'hA);
        check("t5_tc_hold", tc, 1'b0);

        // random stimulus against the arithmetic model
        m_q = q;
        m_wrap = wrap;
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 15) == 0), 4'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) != 0), 4'($urandom));
            #1;
            m_tc = (mode == 2'b01 && m_q == 4'hF) || (mode == 2'b10 && m_q == 4'h0);
            check("rnd_tc", tc, m_tc);
            model_step();
            tick();
            check("rnd_q", q, m_q);
            check("rnd_wrap", wrap, m_wrap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
